// File: rtl/float_pkg.sv
// Shared types and format helpers for the sequential floating-point multiplier.
// Widths are passed explicitly so one package serves every EXP_W/MAN_W instance.
package float_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_NORM,
        ST_DONE
    } state_t;

    localparam int unsigned FLAG_INVALID   = 3;
    localparam int unsigned FLAG_OVERFLOW  = 2;
    localparam int unsigned FLAG_UNDERFLOW = 1;
    localparam int unsigned FLAG_INEXACT   = 0;

    function automatic int unsigned bias_of(input int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

    function automatic int unsigned emax_of(input int unsigned exp_w);
        return (32'd1 << exp_w) - 32'd1;
    endfunction

    // Encodings are right-aligned in 32 bits; callers truncate to their width.
    function automatic logic [31:0] nan_enc(input int unsigned exp_w, input int unsigned man_w);
        return (emax_of(exp_w) << man_w) | (32'd1 << (man_w - 1));
    endfunction

    function automatic logic [31:0] inf_enc(input int unsigned exp_w, input int unsigned man_w,
                                            input logic sign);
        return ({31'd0, sign} << (exp_w + man_w)) | (emax_of(exp_w) << man_w);
    endfunction

endpackage

// File: rtl/mant_mul_seq.sv
// Radix-2 shift-add significand multiplier: one multiplier bit per cycle after a load cycle.
// done is high during the cycle whose rising edge performs the last iteration.
module mant_mul_seq
    import float_pkg::*;
#(
    parameter int unsigned N = 11
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] prod
);

    localparam int unsigned CW = $clog2(N + 1);

    logic [CW-1:0]  cnt_q;
    logic           busy_q;
    logic [N-1:0]   mcand_q;
    logic [2*N-1:0] acc_q;
    logic [N:0]     sum;

    // Upper half accumulates the multiplicand; the multiplier shifts out of the lower half.
    always_comb begin
        sum = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            mcand_q <= '0;
            acc_q   <= '0;
        end else if (start && !busy_q) begin
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            mcand_q <= x;
            acc_q   <= {{N{1'b0}}, y};
        end else if (busy_q) begin
            acc_q <= {sum, acc_q[N-1:1]};
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == CW'(N - 1));
    assign prod = acc_q;

endmodule

// File: rtl/float_mul_seq.sv
// Sequential IEEE-style floating-point multiplier with valid/ready handshakes,
// round-to-nearest-even, denormal flush and full special-case handling.
module float_mul_seq
    import float_pkg::*;
#(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [3:0]             flags
);

    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned N    = MAN_W + 1;
    localparam int unsigned EW2  = EXP_W + 2;
    localparam int unsigned BIAS = bias_of(EXP_W);
    localparam int unsigned EMAX = emax_of(EXP_W);
    localparam logic [W-1:0] NAN_ENC = W'(nan_enc(EXP_W, MAN_W));
    localparam logic [W-1:0] INF_ENC = W'(inf_enc(EXP_W, MAN_W, 1'b0));

    state_t state_q, state_d;

    logic [W-1:0]     a_q, b_q;
    logic [W-1:0]     res_q, res_d;
    logic [3:0]       flags_q, flags_d;
    logic             accept;

    logic             mul_start, mul_busy, mul_done;
    logic [2*N-1:0]   prod;

    logic             sa, sb, sign;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, snan, inf_zero;

    logic             prod_hi;
    logic [2*N-2:0]   norm;
    logic [MAN_W-1:0] man;
    logic             guard, sticky, round_up;
    logic [MAN_W:0]   man_rnd;
    logic [EW2-1:0]   e_fin;
    logic             under, over;

    assign in_ready  = (state_q == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign result    = res_q;
    assign flags     = flags_q;

    // The multiplier loads from the registered operands in the first MUL cycle.
    assign mul_start = (state_q == ST_MUL) && !mul_busy;

    mant_mul_seq #(.N(N)) u_mant_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .x     ({1'b1, ma}),
        .y     ({1'b1, mb}),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)    state_d = ST_MUL;
            ST_MUL:  if (mul_done)  state_d = ST_NORM;
            ST_NORM:                state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sa = a_q[W-1];
        sb = b_q[W-1];
        ea = a_q[W-2 -: EXP_W];
        eb = b_q[W-2 -: EXP_W];
        ma = a_q[MAN_W-1:0];
        mb = b_q[MAN_W-1:0];
        sign     = sa ^ sb;
        a_zero   = (ea == '0);
        b_zero   = (eb == '0);
        a_inf    = (ea == '1) && (ma == '0);
        b_inf    = (eb == '1) && (mb == '0);
        a_nan    = (ea == '1) && (ma != '0);
        b_nan    = (eb == '1) && (mb != '0);
        snan     = (a_nan && !ma[MAN_W-1]) || (b_nan && !mb[MAN_W-1]);
        inf_zero = (a_inf && b_zero) || (b_inf && a_zero);
    end

    // Product lies in [1,4); left-align so the hidden bit is always dropped at the top.
    always_comb begin
        prod_hi  = prod[2*N-1];
        norm     = prod_hi ? prod[2*N-2:0] : {prod[2*N-3:0], 1'b0};
        man      = norm[2*N-2 -: MAN_W];
        guard    = norm[MAN_W];
        sticky   = |norm[MAN_W-1:0];
        round_up = guard && (sticky || man[0]);
        man_rnd  = {1'b0, man} + (MAN_W + 1)'(round_up);
        e_fin    = {2'b00, ea} + {2'b00, eb} - EW2'(BIAS)
                 + EW2'(prod_hi) + EW2'(man_rnd[MAN_W]);
        under    = e_fin[EW2-1] || (e_fin == '0);
        over     = !e_fin[EW2-1] && (e_fin >= EW2'(EMAX));
    end

    always_comb begin
        res_d   = '0;
        flags_d = '0;
        if (a_nan || b_nan || inf_zero) begin
            res_d                 = NAN_ENC;
            flags_d[FLAG_INVALID] = inf_zero || snan;
        end else if (a_inf || b_inf) begin
            res_d = {sign, INF_ENC[W-2:0]};
        end else if (a_zero || b_zero) begin
            res_d = {sign, {(W-1){1'b0}}};
        end else if (under) begin
            res_d                   = {sign, {(W-1){1'b0}}};
            flags_d[FLAG_UNDERFLOW] = 1'b1;
            flags_d[FLAG_INEXACT]   = 1'b1;
        end else if (over) begin
            res_d                  = {sign, INF_ENC[W-2:0]};
            flags_d[FLAG_OVERFLOW] = 1'b1;
            flags_d[FLAG_INEXACT]  = 1'b1;
        end else begin
            res_d                 = {sign, e_fin[EXP_W-1:0], man_rnd[MAN_W-1:0]};
            flags_d[FLAG_INEXACT] = guard || sticky;
        end
    end

    // Output registers are only non-zero while in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            if (accept) begin
                a_q <= a;
                b_q <= b;
            end
            if (state_q == ST_NORM) begin
                res_q   <= res_d;
                flags_q <= flags_d;
            end else if ((state_q == ST_DONE) && out_ready) begin
                res_q   <= '0;
                flags_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_float_mul_seq.sv
// Directed and randomized checks of float_mul_seq at half- and single-precision widths,
// against a real-arithmetic reference model.
module tb_float_mul_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    int          sel = 0;
    logic        iv = 1'b0;
    logic        ordy = 1'b0;
    logic [31:0] a_drv = '0;
    logic [31:0] b_drv = '0;

    logic        ir_h, ov_h, ir_s, ov_s;
    logic [15:0] res_h;
    logic [31:0] res_s;
    logic [3:0]  fl_h, fl_s;

    logic        cur_ir, cur_ov;
    logic [31:0] cur_res;
    logic [3:0]  cur_fl;

    int total = 0;
    int bad   = 0;

    float_mul_seq dut_h (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv && (sel == 0)),
        .in_ready  (ir_h),
        .a         (a_drv[15:0]),
        .b         (b_drv[15:0]),
        .out_valid (ov_h),
        .out_ready (ordy && (sel == 0)),
        .result    (res_h),
        .flags     (fl_h)
    );

    float_mul_seq #(.EXP_W(8), .MAN_W(23)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv && (sel == 1)),
        .in_ready  (ir_s),
        .a         (a_drv),
        .b         (b_drv),
        .out_valid (ov_s),
        .out_ready (ordy && (sel == 1)),
        .result    (res_s),
        .flags     (fl_s)
    );

    always_comb begin
        cur_ir  = (sel == 1) ? ir_s  : ir_h;
        cur_ov  = (sel == 1) ? ov_s  : ov_h;
        cur_res = (sel == 1) ? res_s : {16'h0, res_h};
        cur_fl  = (sel == 1) ? fl_s  : fl_h;
    end

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {flags, result} for a*b in a format with ew exponent and mw mantissa bits.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input int ew, input int mw);
        longint emax  = (longint'(1) << ew) - 1;
        longint bias  = (longint'(1) << (ew - 1)) - 1;
        longint mmask = (longint'(1) << mw) - 1;
        longint sa = (longint'(a) >> (ew + mw)) & 1;
        longint sb = (longint'(b) >> (ew + mw)) & 1;
        longint ea = (longint'(a) >> mw) & emax;
        longint eb = (longint'(b) >> mw) & emax;
        longint ma = longint'(a) & mmask;
        longint mb = longint'(b) & mmask;
        longint s  = sa ^ sb;
        longint r, e, ip;
        logic [3:0] fl = 4'b0;
        bit an = (ea == emax) && (ma != 0);
        bit bn = (eb == emax) && (mb != 0);
        bit ai = (ea == emax) && (ma == 0);
        bit bi = (eb == emax) && (mb == 0);
        bit az = (ea == 0);
        bit bz = (eb == 0);
        bit inv0 = (ai && bz) || (bi && az);
        real scale, sig, frac;
        if (an || bn || inv0) begin
            r = (emax << mw) | (longint'(1) << (mw - 1));
            fl[3] = inv0 || (an && (((ma >> (mw - 1)) & 1) == 0)) || (bn && (((mb >> (mw - 1)) & 1) == 0));
        end else if (ai || bi) begin
            r = (s << (ew + mw)) | (emax << mw);
        end else if (az || bz) begin
            r = s << (ew + mw);
        end else begin
            scale = 1.0;
            for (int i = 0; i < mw; i++) scale = scale * 2.0;
            sig = (1.0 + ma / scale) * (1.0 + mb / scale);
            e = ea + eb - bias;
            if (sig >= 2.0) begin
                sig = sig / 2.0;
                e++;
            end
            ip   = $rtoi(sig * scale);
            frac = sig * scale - ip;
            if (frac > 0.5 || (frac == 0.5 && (ip % 2) == 1)) ip++;
            if (ip >= (longint'(2) << mw)) begin
                ip = ip / 2;
                e++;
            end
            if (e <= 0) begin
                r  = s << (ew + mw);
                fl = 4'b0011;
            end else if (e >= emax) begin
                r  = (s << (ew + mw)) | (emax << mw);
                fl = 4'b0101;
            end else begin
                r     = (s << (ew + mw)) | (e << mw) | (ip - (longint'(1) << mw));
                fl[0] = (frac != 0.0);
            end
        end
        return {fl, r[31:0]};
    endfunction

    function automatic logic [31:0] rand_op(input int ew, input int mw);
        int emax = (1 << ew) - 1;
        int bias = (1 << (ew - 1)) - 1;
        int r    = $urandom_range(0, 15);
        longint s = $urandom_range(0, 1);
        longint m = longint'($urandom) & ((longint'(1) << mw) - 1);
        longint e;
        if (r == 0)      e = 0;
        else if (r == 1) e = emax;
        else if (r < 6)  e = $urandom_range(1, emax - 1);
        else             e = bias - bias / 2 + $urandom_range(0, bias);
        if ($urandom_range(0, 3) == 0) m = 0;
        return 32'((s << (ew + mw)) | (e << mw) | m);
    endfunction

    task automatic finish_accept();
        @(posedge clk);
        @(negedge clk);
        iv    = 1'b0;
        a_drv = $urandom;
        b_drv = $urandom;
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input string tag);
        int k = 0;
        while (!cur_ir && k < 64) begin
            @(negedge clk);
            k++;
        end
        check({tag, " in_ready"}, 40'(cur_ir), 40'd1);
        a_drv = a;
        b_drv = b;
        iv    = 1'b1;
        finish_accept();
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!cur_ov && k < 64) begin
            check({tag, " quiet"}, {4'h0, cur_fl, cur_res}, 40'd0);
            @(negedge clk);
            k++;
        end
        check({tag, " latency"}, 40'(k), 40'(((sel == 1) ? 23 : 10) + 3));
    endtask

    task automatic release_out(input string tag);
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        check({tag, " release"}, {2'b0, cur_ov, cur_ir, cur_fl, cur_res}, {2'b0, 2'b01, 36'd0});
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [35:0] exp,
                          input int stall, input string tag);
        start_op(a, b, tag);
        wait_done(tag);
        check({tag, " result"}, {4'h0, cur_fl, cur_res}, {4'h0, exp});
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, " hold"}, {2'b0, cur_ov, cur_ir, cur_fl, cur_res}, {2'b0, 2'b10, exp});
        end
        release_out(tag);
    endtask

    initial begin
        int ew, mw, stall;
        logic [31:0] ra, rb;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset h", {2'b0, ov_h, ir_h, fl_h, 16'h0, res_h}, {2'b0, 2'b01, 36'd0});
        check("reset s", {2'b0, ov_s, ir_s, fl_s, res_s}, {2'b0, 2'b01, 36'd0});

        sel = 0;
        run_op(32'h3E00, 32'h3E00, {4'h0, 32'h4080}, 0, "1.5sq");
        run_op(32'h3C01, 32'h3C01, {4'h1, 32'h3C02}, 0, "inexact");
        run_op(32'hC000, 32'h3E00, {4'h0, 32'hC200}, 0, "neg");
        run_op(32'h7BFF, 32'h4000, {4'h5, 32'h7C00}, 0, "ovf");
        run_op(32'h0400, 32'h3800, {4'h3, 32'h0000}, 0, "unf");
        run_op(32'h7C00, 32'h0000, {4'h8, 32'h7E00}, 0, "inf*0");
        run_op(32'hFC00, 32'h4000, {4'h0, 32'hFC00}, 0, "-inf*2");
        run_op(32'h7D00, 32'h3C00, {4'h8, 32'h7E00}, 0, "snan");
        run_op(32'h7E00, 32'h3C00, {4'h0, 32'h7E00}, 0, "qnan");
        run_op(32'h8000, 32'h3C00, {4'h0, 32'h8000}, 0, "-zero");
        run_op(32'h3C01, 32'h3E00, {4'h1, 32'h3E02}, 0, "tie up");
        run_op(32'h3C03, 32'h3E00, {4'h1, 32'h3E04}, 0, "tie even");
        run_op(32'h3FE0, 32'h3C10, {4'h1, 32'h4000}, 0, "rnd carry");
        run_op(32'h3E00, 32'h3E00, {4'h0, 32'h4080}, 5, "stall5");

        // New operands presented while the previous result is being taken.
        start_op(32'h3E00, 32'h3E00, "b2b first");
        wait_done("b2b first");
        check("b2b first result", {4'h0, cur_fl, cur_res}, {8'h0, 32'h4080});
        a_drv = 32'h3C01;
        b_drv = 32'h3E00;
        iv    = 1'b1;
        ordy  = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        check("b2b not accepted in DONE", 40'({cur_ov, cur_ir}), 40'b01);
        finish_accept();
        wait_done("b2b second");
        check("b2b second result", {4'h0, cur_fl, cur_res}, {4'h0, 4'h1, 32'h3E02});
        release_out("b2b second");

        start_op(32'h3E00, 32'h3E00, "abort");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort state", {2'b0, cur_ov, cur_ir, cur_fl, cur_res}, {2'b0, 2'b01, 36'd0});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("abort no stale", {3'b0, cur_ov, cur_fl, cur_res}, 40'd0);
        end

        for (int c = 0; c < 2; c++) begin
            sel = c;
            ew  = (c == 1) ? 8 : 5;
            mw  = (c == 1) ? 23 : 10;
            for (int n = 0; n < 1000; n++) begin
                ra    = rand_op(ew, mw);
                rb    = rand_op(ew, mw);
                stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
                repeat ($urandom_range(0, 1)) @(negedge clk);
                run_op(ra, rb, model(ra, rb, ew, mw), stall, (c == 1) ? "rand32" : "rand16");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
